// File: rtl/acc_seq_pkg.sv
// acc_seq_pkg: shared opcode/state encodings for the accumulator sequencer
package acc_seq_pkg;
    localparam int OPC_W = 4;
    localparam int IMM_W = 4;
    typedef enum logic [OPC_W-1:0] {
        OP_NOP = 4'h0, OP_LD, OP_ST, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
        OP_LDI, OP_SHL, OP_SHR
    } opcode_e;
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;
endpackage

// File: rtl/acc_alu.sv
// acc_alu: combinational accumulator ALU with flag-update enables
module acc_alu
    import acc_seq_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] acc,
    input  logic [DATA_WIDTH-1:0] operand,
    input  opcode_e               opcode,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  carry,
    output logic                  zero,
    output logic                  updates_z,
    output logic                  updates_c
);
    logic [DATA_WIDTH:0] sum, diff;
    assign sum  = {1'b0, acc} + {1'b0, operand};
    assign diff = {1'b0, acc} - {1'b0, operand};
    always_comb begin
        result = acc;
        carry  = 1'b0;
        case (opcode)
            OP_LD:   result = operand;
            OP_ADD:  {carry, result} = sum;
            OP_SUB:  {carry, result} = diff;
            OP_AND:  result = acc & operand;
            OP_OR:   result = acc | operand;
            OP_XOR:  result = acc ^ operand;
            OP_LDI:  result = operand;
            OP_SHL:  {carry, result} = {acc, 1'b0};
            OP_SHR:  {result, carry} = {1'b0, acc};
            default: result = acc;
        endcase
        zero      = result == '0;
        updates_z = opcode inside {OP_LD, [OP_ADD:OP_SHR]};
        updates_c = opcode inside {[OP_ADD:OP_XOR], OP_SHL, OP_SHR};
    end
endmodule

// File: rtl/acc_sequencer.sv
// acc_sequencer: 3-cycle IDLE/EXEC/DONE accumulator initiator for a 4-entry register file
module acc_sequencer
    import acc_seq_pkg::*;
#(
    parameter int                       DATA_WIDTH     = 8,
    parameter int                       REG_ADDR_WIDTH = 2,
    parameter logic [DATA_WIDTH-1:0]    ACC_RESET      = 8'h00
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [7:0]                instr,
    input  logic                      instr_valid,
    output logic                      instr_ready,
    output logic [REG_ADDR_WIDTH-1:0] register_address,
    output logic                      we,
    output logic [DATA_WIDTH-1:0]     accumulator_output,
    input  logic [DATA_WIDTH-1:0]     register_value,
    output logic [DATA_WIDTH-1:0]     acc,
    output logic                      zero_flag,
    output logic                      carry_flag,
    output logic                      done,
    output logic                      illegal
);
    state_e                state, state_nxt;
    logic [7:0]            instr_q;
    opcode_e               op;
    logic [DATA_WIDTH-1:0] operand, result;
    logic                  carry, zero, updates_z, updates_c;
    assign op                 = opcode_e'(instr_q[7:4]);
    assign operand            = op == OP_LDI ? {{(DATA_WIDTH-IMM_W){1'b0}}, instr_q[IMM_W-1:0]} : register_value;
    assign accumulator_output = acc;
    acc_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
        .acc(acc), .operand(operand), .opcode(op), .result(result),
        .carry(carry), .zero(zero), .updates_z(updates_z), .updates_c(updates_c)
    );
    // Control outputs decode from state so an async reset clears them instantly
    always_comb begin
        state_nxt   = state == IDLE ? (instr_valid ? EXEC : IDLE) : state == EXEC ? DONE : IDLE;
        instr_ready = state == IDLE;
        we          = state == EXEC && op == OP_ST;
        done        = state == DONE;
        illegal     = state == DONE && instr_q[7:4] > OP_SHR;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            instr_q          <= '0;
            register_address <= '0;
            acc              <= ACC_RESET;
            zero_flag        <= 1'b0;
            carry_flag       <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && instr_valid) begin
                instr_q          <= instr;
                register_address <= instr[REG_ADDR_WIDTH-1:0];
            end
            if (state == EXEC) begin
                acc <= result;
                if (updates_z) zero_flag <= zero;
                if (updates_c) carry_flag <= carry;
            end
        end
    end
endmodule

// File: doc/acc_sequencer.md
Name: acc_sequencer

Overview:
- Accumulator-side initiator for the 4-entry, 8-bit register file.
- Accepts 8-bit instructions over a valid/ready handshake and owns the 8-bit accumulator and flags.
- Reads the register file combinationally (address to value in the same cycle) and writes it through register_address/we/accumulator_output; the register file latches writes on the rising clk edge.
- Executes one instruction per 3-cycle sequence (IDLE -> EXEC -> DONE).

Parameters:
- DATA_WIDTH, 8, accumulator and register data width.
- REG_ADDR_WIDTH, 2, register file address width (4 registers).
- ACC_RESET, 8'h00, accumulator value after reset.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- instr  input  8  instruction: [7:4] opcode, [3:0] imm4 (LDI only), [1:0] register index.
- instr_valid  input  1  instr is valid this cycle.
- instr_ready  output  1  sequencer can accept an instruction.
- register_address  output  REG_ADDR_WIDTH  register file address.
- we  output  1  register file write enable.
- accumulator_output  output  DATA_WIDTH  write data to register file; always equals acc.
- register_value  input  DATA_WIDTH  combinational read data from register file.
- acc  output  DATA_WIDTH  current accumulator.
- zero_flag  output  1  last flag-updating result was 0.
- carry_flag  output  1  ADD carry-out / SUB borrow / shifted-out bit.
- done  output  1  one-cycle pulse: instruction retired.
- illegal  output  1  one-cycle pulse, coincident with done, for undefined opcode.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, acc=ACC_RESET, zero_flag=0, carry_flag=0, register_address=0, we=0, done=0, illegal=0. All outputs take these values immediately, mid-instruction included. Any in-flight ST is abandoned: we drops at once and no write occurs.
- IDLE: instr_ready=1. When instr_valid=1, capture instr into instr_q and register_address<=instr[1:0], then go to EXEC. When instr_valid=0, stay in IDLE.
- EXEC: instr_ready=0. The ALU uses acc, register_value and instr_q. Results register at the end of EXEC, then go to DONE.
- DONE: done=1 for exactly one cycle, illegal=1 if the opcode was undefined, instr_ready=0. Then go to IDLE.
- Latency: handshake at edge T, EXEC in cycle T+1, done in cycle T+2, instr_ready high again in T+3. Peak throughput is 1 instruction per 3 cycles.
- Opcodes:
  - 0 NOP: no change.
  - 1 LD: acc<=R; Z updated; C unchanged.
  - 2 ST: we=1 during EXEC only, R<=acc at the EXEC-end edge; flags unchanged.
  - 3 ADD: {C,acc}<=acc+R (9-bit).
  - 4 SUB: acc<=acc-R mod 256; C=1 if acc<R (borrow).
  - 5 AND, 6 OR, 7 XOR: acc<=acc op R; C<=0.
  - 8 LDI: acc<={4'b0,imm4}; Z updated; C unchanged.
  - 9 SHL: C<=acc[7]; acc<=acc<<1.
  - A SHR: C<=acc[0]; acc<=acc>>1 (logical).
  - B-F: treated as NOP and illegal pulses in DONE.
- Z rule: for opcodes 1 and 3-A, Z = (new acc == 0).
- Arithmetic wraps modulo 2^DATA_WIDTH; there is no saturation.
- we is asserted only in EXEC of ST and is never high in IDLE or DONE.
- register_address holds its value from capture until the next accept.
- instr_valid while instr_ready=0 is ignored; the source holds instr until the handshake.
- Back-to-back ST Rn then LD Rn: LD reads the stored value, because the write commits before the LD's EXEC cycle.

Decomposition:
- Shared package acc_seq_pkg:
  - opcode_e enum (4-bit, values above).
  - state_e enum {IDLE, EXEC, DONE}.
  - localparams OPC_W=4 and IMM_W=4.
- Sub-module acc_alu (combinational): inputs acc, operand and opcode; outputs result, carry, zero and updates_z/updates_c enables.
- The FSM, registers and handshake stay in acc_sequencer.

Test Plan:
- Reset, then LDI 5 (8'h85): done at T+2, acc=8'h05, Z=0, instr_ready returns at T+3; the 4-entry register file's power-up values (R0=1, R1-R3=0) are untouched.
- LDI 5, ST R2 (8'h22), LD R0 (8'h10): we=1 for exactly one cycle with register_address=2, data=5; final acc=1.
- LDI 15, ST R1, ADD R1 x17 (acc accumulates 15*n): the ADD that takes acc from 255 to 14 sets C=1, Z=0. Then SUB R1 with acc=14, R1=15: acc=8'hFF, C=1.
- LDI 1, SHR: acc=0, C=1, Z=1. Then XOR R0 (R0=1): acc=1, C=0, Z=0.
- Opcode 8'hC3: no register write, acc unchanged, illegal and done both high for one cycle.
- Assert rst_n=0 during EXEC of ST R3: we drops asynchronously, R3 stays 0, acc=0, state=IDLE, instr_ready=1 after release.
